leds_pattern: RTL and testbench

Parametrised LED pattern generator for the IceZUM Alhambra LED port: the next step beyond a fixed constant on `LPORT`. It drives a `WIDTH`-bit LED bus from one of four runtime-selectable modes: static pattern, blinking pattern, bouncing single LED, and binary counter. All modes advance on a shared prescaled tick. It sits directly between board pins (mode switches) and `LPORT` in top-level examples.

---
 rtl/leds_pattern.sv | 121 ++++++++++++
 tb/tb_leds_pattern.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/leds_pattern.sv
// LED pattern generator: static, blink, bouncing LED and binary counter modes,
// all advancing on a shared prescaled tick.
module leds_pattern #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIV     = 12000000,
  parameter logic [7:0]  PATTERN = 8'hAA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] LPORT,
  output logic             tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  // Zero-extend or truncate the 8-bit pattern to the LED width
  function automatic logic [WIDTH-1:0] fit_pattern(input logic [7:0] p);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < 8) r[i] = p[i[2:0]];
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0] PAT = fit_pattern(PATTERN);

  function automatic logic [WIDTH-1:0] init_value(input mode_e m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_BOUNCE: r = WIDTH'(1);
      MODE_COUNT:  r = '0;
      default:     r = PAT;
    endcase
    return r;
  endfunction

  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_down_q, dir_down_d;
  logic             tick_q, tick_d;
  logic             step;
  mode_e            mode_in;

  assign step    = (cnt_q == CNT_MAX);
  assign mode_in = mode_e'(mode);

  // Next-state: a mode change wins over a coincident step
  always_comb begin
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    led_d      = led_q;
    dir_down_d = dir_down_q;
    tick_d     = 1'b0;
    if (mode_in != mode_q) begin
      mode_d     = mode_in;
      cnt_d      = '0;
      led_d      = init_value(mode_in);
      dir_down_d = 1'b0;
    end else begin
      cnt_d  = step ? '0 : cnt_q + CW'(1);
      tick_d = step;
      if (step) begin
        case (mode_q)
          MODE_BLINK: led_d = ~led_q;
          MODE_BOUNCE: begin
            if (WIDTH == 1) begin
              led_d = led_q;
            end else if (!dir_down_q) begin
              if (led_q[WIDTH-1]) begin
                led_d      = led_q >> 1;
                dir_down_d = 1'b1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                led_d      = led_q << 1;
                dir_down_d = 1'b0;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          MODE_COUNT: led_d = led_q + WIDTH'(1);
          default:    led_d = led_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_STATIC;
      cnt_q      <= '0;
      led_q      <= PAT;
      dir_down_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
      dir_down_q <= dir_down_d;
      tick_q     <= tick_d;
    end
  end

  assign LPORT = led_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_leds_pattern.sv
// Randomised and directed bench for leds_pattern; three instances cover the
// default configuration, a single LED and a divide-by-one prescaler.
module tb_leds_pattern;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;

  logic [7:0] led0, led2;
  logic [0:0] led1;
  logic       tick0, tick1, tick2;

  always #5 clk = ~clk;

  leds_pattern #(.WIDTH(8), .DIV(4), .PATTERN(8'hAA)) u_main (
    .clk(clk), .rst(rst), .mode(mode), .LPORT(led0), .tick(tick0));
  leds_pattern #(.WIDTH(1), .DIV(4), .PATTERN(8'hAA)) u_w1 (
    .clk(clk), .rst(rst), .mode(mode), .LPORT(led1), .tick(tick1));
  leds_pattern #(.WIDTH(8), .DIV(1), .PATTERN(8'hAA)) u_d1 (
    .clk(clk), .rst(rst), .mode(mode), .LPORT(led2), .tick(tick2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode, steps taken in this mode, cycles into current step
  int mw[3]   = '{8, 1, 8};
  int mdiv[3] = '{4, 4, 1};
  int mmode[3];
  int mn[3];
  int mc[3];
  bit mt[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // LED value from the mode rules, written in terms of step count only
  function automatic logic [7:0] exp_led(input int w, input int m, input int n);
    logic [7:0] mask, p;
    int period, k, pos;
    mask = (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
    p = 8'hAA & mask;
    case (m)
      0: return p;
      1: return (n % 2 == 1) ? (~p & mask) : p;
      2: begin
        if (w == 1) return 8'h01;
        period = 2 * (w - 1);
        k = n % period;
        pos = (k < w) ? k : period - k;
        return 8'(1 << pos);
      end
      default: return 8'(n % (1 << w));
    endcase
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mmode[i] = 0; mn[i] = 0; mc[i] = 0; mt[i] = 1'b0;
      end else if (int'(mode) != mmode[i]) begin
        mmode[i] = int'(mode); mn[i] = 0; mc[i] = 0; mt[i] = 1'b0;
      end else if (mc[i] + 1 == mdiv[i]) begin
        mc[i] = 0; mn[i]++; mt[i] = 1'b1;
      end else begin
        mc[i]++; mt[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input int count);
    for (int j = 0; j < count; j++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("led_w8",   32'(led0),  32'(exp_led(8, mmode[0], mn[0])));
      chk("tick_w8",  32'(tick0), 32'(mt[0]));
      chk("led_w1",   32'(led1),  32'(exp_led(1, mmode[1], mn[1])));
      chk("tick_w1",  32'(tick1), 32'(mt[1]));
      chk("led_div1", 32'(led2),  32'(exp_led(8, mmode[2], mn[2])));
      chk("tick_div1",32'(tick2), 32'(mt[2]));
    end
  endtask

  initial begin
    bit found;
    rst  = 1'b1;
    mode = 2'd0;
    cyc(2);
    rst = 1'b0;
    cyc(20);

    mode = 2'd1;
    cyc(20);

    mode = 2'd2;
    cyc(64);

    mode = 2'd3;
    cyc(1040);

    // Switch to bounce on the exact cycle a step is due
    found = 1'b0;
    for (int j = 0; j < 8 && !found; j++) begin
      if (mc[0] == 3) found = 1'b1;
      else cyc(1);
    end
    chk("wait_step_due", 32'(found), 32'd1);
    mode = 2'd2;
    cyc(1);
    chk("chg_led", 32'(led0), 32'h01);
    chk("chg_tick", 32'(tick0), 32'd0);
    cyc(12);

    // Reset mid-bounce while the lit LED is bit 5
    found = 1'b0;
    for (int j = 0; j < 80 && !found; j++) begin
      if (mmode[0] == 2 && exp_led(8, 2, mn[0]) == 8'h20 && led0 == 8'h20) found = 1'b1;
      else cyc(1);
    end
    chk("wait_led20", 32'(found), 32'd1);
    rst = 1'b1;
    cyc(1);
    chk("rst_led", 32'(led0), 32'hAA);
    chk("rst_tick", 32'(tick0), 32'd0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_led", 32'(led0), 32'h01);

    // Random modes, hold lengths (including one-cycle glitches) and resets
    for (int s = 0; s < 300; s++) begin
      mode = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 15) == 0);
      cyc(1);
      rst = 1'b0;
      cyc(int'($urandom_range(0, 30)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
